// File: rtl/jt51_i2s_tx.sv
// jt51_i2s_tx: stereo 16-bit I2S serialiser with one-entry hold buffer.
// Define JT51_I2S_LJ_EN for left-justified output (no one-bit delay).
module jt51_i2s_tx #(
    parameter int HALF_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_in,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        frame_start,
    output logic        overrun,
    output logic        underrun
);
    localparam int DW = $clog2(HALF_DIV);

    logic [DW-1:0] div;
    logic [5:0]    slot, slot_n;
    logic [15:0]   hold_l, hold_r, cur_l, cur_r, nxt_l, nxt_r, w;
    logic          hold_valid, tick, fall, load, bit_n;
    logic [4:0]    s;
    logic [3:0]    idx;

    always_comb begin
        tick   = div == DW'(HALF_DIV - 1);
        fall   = tick && bclk;
        load   = fall && slot == 6'd63;
        slot_n = slot + 6'd1;
        nxt_l  = load && hold_valid ? hold_l : cur_l;
        nxt_r  = load && hold_valid ? hold_r : cur_r;
        w      = slot_n[5] ? nxt_r : nxt_l;
        s      = slot_n[4:0];
`ifdef JT51_I2S_LJ_EN
        idx    = 4'd15 - s[3:0];
        bit_n  = !s[4] && w[idx];
`else
        // standard I2S: MSB lands one bit after the word-select edge
        idx    = 4'(5'd16 - s);
        bit_n  = s >= 5'd1 && s <= 5'd16 && w[idx];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            bclk        <= 1'b0;
            slot        <= '0;
            lrck        <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            hold_valid  <= 1'b0;
            cur_l       <= '0;
            cur_r       <= '0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            bclk        <= tick ? !bclk : bclk;
            frame_start <= load;
            underrun    <= load && !hold_valid;
            overrun     <= sample_in && hold_valid && !load;
            if (fall) begin
                slot  <= slot_n;
                lrck  <= slot_n[5];
                sdata <= bit_n;
                cur_l <= nxt_l;
                cur_r <= nxt_r;
            end
            // a strobe coinciding with a load refills the hold after the load drained it
            if (sample_in) begin
                hold_l     <= left_in;
                hold_r     <= right_in;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule
